// File: rtl/afu_mmio_fifo_pkg.sv
// Shared definitions for the MMIO FIFO bank AFU.
// Contains the register map, STAT/control bit positions, the STAT word
// layout and a minimal stand-in for the CCI-P interface types. The stand-in
// carries only the fields this AFU touches, at the platform's field names.
// No ports.

`ifndef AFU_ACCEL_UUID
`define AFU_ACCEL_UUID 128'hC000_C966_0D82_4272_9AEF_FE5F_8406_8000
`endif

package afu_mmio_fifo_pkg;

    // Register map (32-bit-word MMIO addresses, 64-bit registers)
    localparam logic [15:0] DFH_ADDR      = 16'h0000;
    localparam logic [15:0] AFU_ID_L_ADDR = 16'h0002;
    localparam logic [15:0] AFU_ID_H_ADDR = 16'h0004;
    localparam logic [15:0] CH_BASE_ADDR  = 16'h0020;
    localparam int          CH_STRIDE     = 4;

    // DFH: type AFU in [63:60], end-of-list in bit 40
    localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

    // STAT read bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_UDF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // STAT write control bit positions
    localparam int CTL_FLUSH = 0;
    localparam int CTL_CLR   = 1;

    typedef struct packed {
        logic [47:0] rsvdHi;
        logic [7:0]  count;
        logic [3:0]  rsvdLo;
        logic        udf;
        logic        ovf;
        logic        full;
        logic        empty;
    } t_stat;

    // CCI-P subset
    typedef logic [8:0] t_ccip_tid;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        t_ccip_tid   tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef logic [27:0] t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_tid tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // Builds the STAT register word from a channel's status
    function automatic t_stat packStat(input logic [7:0] count, input logic udf,
                                       input logic ovf, input logic full,
                                       input logic empty);
        logic [63:0] w;
        w = '0;
        w[STAT_CNT_LSB +: 8] = count;
        w[STAT_UDF]          = udf;
        w[STAT_OVF]          = ovf;
        w[STAT_FULL]         = full;
        w[STAT_EMPTY]        = empty;
        return t_stat'(w);
    endfunction

endpackage

// File: rtl/afu_mmio_fifo_bank_chan.sv
// One FIFO channel of the MMIO FIFO bank.
// Ports: clk/rst; push_i/pop_i/flush_i/clr_i one-cycle commands (at most one
// of push/pop per cycle); din_i push data; dout_o combinational head entry;
// count_o/full_o/empty_o occupancy; ovf_o/udf_o sticky error flags.

module mmio_fifo_chan #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic                       clr_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic                       ovf_o,
    output logic                       udf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             memWe;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;
    assign dout_o  = mem_q[rdPtr_q];
    assign memWe   = push_i & ~full_o & ~flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is not reset: contents behind an empty FIFO are don't-care
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[wrPtr_q] <= din_i;
        end
    end

    // Overflowing pushes and underflowing pops leave the pointers alone and
    // only raise their sticky flag; flush wins over a simultaneous push/pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else if (push_i) begin
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                wrPtr_d = wrPtr_q + AW'(1);
                count_d = count_q + (AW+1)'(1);
            end
        end else if (pop_i) begin
            if (empty_o) begin
                udf_d = 1'b1;
            end else begin
                rdPtr_d = rdPtr_q + AW'(1);
                count_d = count_q - (AW+1)'(1);
            end
        end
        if (clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

endmodule

// File: rtl/afu_mmio_fifo_bank.sv
// CCI-P MMIO AFU exposing NUM_CH independent FIFOs plus the DFH/AFU_ID block.
// Ports: clk, rst (async, active-high); rx CCI-P receive (c0 MMIO read/write
// requests); tx CCI-P transmit (c2 MMIO read responses, c0/c1 held at 0).

module afu_mmio_fifo_bank
    import afu_mmio_fifo_pkg::*;
#(
    parameter int           NUM_CH = 4,
    parameter int           DEPTH  = 8,
    parameter int           WIDTH  = 64,
    parameter logic [127:0] AFU_ID = `AFU_ACCEL_UUID
) (
    input  logic        clk,
    input  logic        rst,
    input  t_if_ccip_Rx rx,
    output t_if_ccip_Tx tx
);

    localparam int AW = $clog2(DEPTH);

    t_ccip_c0_ReqMmioHdr reqHdr;
    logic                rdReq, wrReq, isStat;
    logic [NUM_CH-1:0]   chSel;
    logic [NUM_CH-1:0]   push, pop, flush, clr, full, empty, ovf, udf;
    logic [WIDTH-1:0]    chDout [NUM_CH];
    logic [AW:0]         chCount [NUM_CH];
    logic                rspValid_q;
    t_ccip_tid           rspTid_q;
    logic [63:0]         rspData_q, rspData_d;
    logic                unusedBits;

    assign reqHdr     = t_ccip_c0_ReqMmioHdr'(rx.c0.hdr);
    assign unusedBits = ^{rx, reqHdr.length, reqHdr.rsvd};

    // The header is shared, so a read presented together with a write wins
    assign rdReq = rx.c0.mmioRdValid;
    assign wrReq = rx.c0.mmioWrValid & ~rx.c0.mmioRdValid;

    // Channel decode: one-hot channel select, isStat marks the STAT slot
    always_comb begin
        chSel  = '0;
        isStat = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (reqHdr.address == CH_BASE_ADDR + 16'(CH_STRIDE * c)) begin
                chSel[c] = 1'b1;
            end
            if (reqHdr.address == CH_BASE_ADDR + 16'(CH_STRIDE * c + 2)) begin
                chSel[c] = 1'b1;
                isStat   = 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gChan
        assign push[c]  = wrReq & chSel[c] & ~isStat;
        assign pop[c]   = rdReq & chSel[c] & ~isStat;
        assign flush[c] = wrReq & chSel[c] & isStat & rx.c0.data[CTL_FLUSH];
        assign clr[c]   = wrReq & chSel[c] & isStat & rx.c0.data[CTL_CLR];

        mmio_fifo_chan #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) uChan (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[c]),
            .pop_i   (pop[c]),
            .flush_i (flush[c]),
            .clr_i   (clr[c]),
            .din_i   (rx.c0.data[WIDTH-1:0]),
            .dout_o  (chDout[c]),
            .count_o (chCount[c]),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .ovf_o   (ovf[c]),
            .udf_o   (udf[c])
        );
    end

    // Response mux; an empty DATA read returns 0 rather than stale storage
    always_comb begin
        rspData_d = '0;
        if (reqHdr.address == DFH_ADDR) begin
            rspData_d = DFH_VALUE;
        end else if (reqHdr.address == AFU_ID_L_ADDR) begin
            rspData_d = AFU_ID[63:0];
        end else if (reqHdr.address == AFU_ID_H_ADDR) begin
            rspData_d = AFU_ID[127:64];
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (chSel[c]) begin
                if (isStat) begin
                    rspData_d = packStat(8'(chCount[c]), udf[c], ovf[c], full[c], empty[c]);
                end else if (!empty[c]) begin
                    rspData_d = 64'(chDout[c]);
                end
            end
        end
    end

    // Response register: loads on the same edge the pop takes effect, so the
    // reply carries the pre-pop head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rspValid_q <= 1'b0;
            rspTid_q   <= '0;
            rspData_q  <= '0;
        end else begin
            rspValid_q <= rdReq;
            if (rdReq) begin
                rspTid_q  <= reqHdr.tid;
                rspData_q <= rspData_d;
            end
        end
    end

    always_comb begin
        tx                = '0;
        tx.c2.mmioRdValid = rspValid_q;
        tx.c2.hdr.tid     = rspTid_q;
        tx.c2.data        = rspData_q;
    end

endmodule

// File: tb/tb_afu_mmio_fifo_bank.sv
// Self-checking bench for afu_mmio_fifo_bank: directed register-map and FIFO
// sequences followed by randomized MMIO traffic, scored against a queue-based
// model of the channel behaviour.

module tb_afu_mmio_fifo_bank;
    import afu_mmio_fifo_pkg::*;

    localparam int           NUM_CH    = 4;
    localparam int           DEPTH     = 8;
    localparam int           WIDTH     = 64;
    localparam logic [127:0] TB_AFU_ID = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    logic [8:0]  tidCnt = '0;
    expT         expQ[$];

    logic [63:0] chQ [NUM_CH][$];
    bit          ovfM [NUM_CH];
    bit          udfM [NUM_CH];

    afu_mmio_fifo_bank #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .AFU_ID (TB_AFU_ID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .tx  (tx)
    );

    // Free-running clock and a cycle counter used to time responses
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic logic [15:0] dataAddr(input int c);
        return 16'(32'h20 + 4 * c);
    endfunction

    function automatic logic [15:0] statAddr(input int c);
        return 16'(32'h22 + 4 * c);
    endfunction

    function automatic void resetModel();
        for (int c = 0; c < NUM_CH; c++) begin
            chQ[c].delete();
            ovfM[c] = 1'b0;
            udfM[c] = 1'b0;
        end
    endfunction

    // Reference behaviour of an MMIO read, including its side effects
    function automatic logic [63:0] modelRead(input logic [15:0] addr);
        logic [63:0] r;
        r = 64'h0;
        if (addr == 16'h0000) r = 64'h1000_0100_0000_0000;
        else if (addr == 16'h0002) r = TB_AFU_ID[63:0];
        else if (addr == 16'h0004) r = TB_AFU_ID[127:64];
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == dataAddr(c)) begin
                if (chQ[c].size() == 0) udfM[c] = 1'b1;
                else r = chQ[c].pop_front();
            end else if (addr == statAddr(c)) begin
                r = 64'(chQ[c].size()) * 256
                    + (udfM[c] ? 64'd8 : 64'd0) + (ovfM[c] ? 64'd4 : 64'd0)
                    + ((chQ[c].size() == DEPTH) ? 64'd2 : 64'd0)
                    + ((chQ[c].size() == 0) ? 64'd1 : 64'd0);
            end
        end
        return r;
    endfunction

    function automatic void modelWrite(input logic [15:0] addr, input logic [63:0] d);
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == dataAddr(c)) begin
                if (chQ[c].size() == DEPTH) ovfM[c] = 1'b1;
                else chQ[c].push_back(d);
            end else if (addr == statAddr(c)) begin
                if (d[0]) chQ[c].delete();
                if (d[1]) begin
                    ovfM[c] = 1'b0;
                    udfM[c] = 1'b0;
                end
            end
        end
    endfunction

    // Drives one cycle of MMIO request and records the expected outcome
    task automatic applyStimulus(input bit doRd, input bit doWr,
                                 input logic [15:0] addr, input logic [63:0] d);
        t_ccip_c0_ReqMmioHdr h;
        expT e;
        @(posedge clk);
        #1;
        h             = '0;
        h.address     = addr;
        h.tid         = tidCnt;
        rx            = '0;
        rx.c0.hdr     = t_ccip_c0_RspMemHdr'(h);
        rx.c0.data    = 512'(d);
        rx.c0.mmioRdValid = doRd;
        rx.c0.mmioWrValid = doWr;
        if (doRd) begin
            e.due  = cycle + 1;
            e.tid  = tidCnt;
            e.data = modelRead(addr);
            expQ.push_back(e);
        end else if (doWr) begin
            modelWrite(addr, d);
        end
        tidCnt = tidCnt + 9'd1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [63:0] d);
        applyStimulus(1'b0, 1'b1, addr, d);
    endtask

    task automatic rd(input logic [15:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 64'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, 64'h0);
    endtask

    // Monitor: compares every response against the scoreboard head
    always @(negedge clk) begin
        if (tx.c2.mmioRdValid) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(tx.c2.hdr.tid), 64'h1FF);
            end else begin
                expT e;
                e = expQ.pop_front();
                checkOutput("rsp_data", tx.c2.data, e.data);
                checkOutput("rsp_tid", 64'(tx.c2.hdr.tid), 64'(e.tid));
                checkOutput("rsp_cycle", 64'(cycle), 64'(e.due));
                checkOutput("tx_c0c1_zero", 64'((tx.c0 == '0) && (tx.c1 == '0)), 64'd1);
            end
        end else if (expQ.size() > 0 && cycle >= expQ[0].due) begin
            checkOutput("rsp_missing", 64'd0, 64'd1);
            void'(expQ.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        rx  = '0;
        resetModel();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_tx_zero", 64'(tx == '0), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // DFH block
        rd(16'h0000); rd(16'h0002); rd(16'h0004); rd(16'h0006); rd(16'h0008);

        // Channel 0 basic push/pop
        wr(dataAddr(0), 64'h11); wr(dataAddr(0), 64'h22); wr(dataAddr(0), 64'h33);
        rd(statAddr(0));
        rd(dataAddr(0)); rd(dataAddr(0)); rd(dataAddr(0));
        rd(statAddr(0));

        // Channel 1 overflow, drain, underflow, clear
        for (int i = 1; i <= 9; i++) wr(dataAddr(1), 64'(i));
        rd(statAddr(1));
        for (int i = 0; i < 9; i++) rd(dataAddr(1));
        rd(statAddr(1));
        wr(statAddr(1), 64'h2);
        rd(statAddr(1));

        // Channel 2 pointer wrap
        for (int i = 1; i <= 5; i++) wr(dataAddr(2), 64'(i));
        for (int i = 0; i < 3; i++) rd(dataAddr(2));
        for (int i = 0; i < 6; i++) wr(dataAddr(2), 64'h100 + 64'(i));
        rd(statAddr(2));
        for (int i = 0; i < 8; i++) begin
            rd(dataAddr(2));
            rd(statAddr(2));
        end

        // Isolation, flush, unmapped address
        wr(dataAddr(0), 64'hAA); wr(dataAddr(3), 64'hBB);
        wr(statAddr(0), 64'h1);
        rd(statAddr(0)); rd(statAddr(3));
        wr(16'h0100, 64'h5); rd(16'h0100);
        for (int c = 0; c < NUM_CH; c++) rd(statAddr(c));
        rd(dataAddr(3));
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            int r, c;
            logic [63:0] d;
            r = int'($urandom_range(0, 99));
            c = int'($urandom_range(0, NUM_CH - 1));
            d = {$urandom, $urandom};
            if (r < 40) wr(dataAddr(c), d);
            else if (r < 70) rd(dataAddr(c));
            else if (r < 80) rd(statAddr(c));
            else if (r < 84) wr(statAddr(c), 64'($urandom_range(0, 3)));
            else if (r < 89) applyStimulus(1'b1, 1'b1, (r[0] ? dataAddr(c) : statAddr(c)), d);
            else if (r < 93) rd(16'(2 * $urandom_range(0, 4)));
            else if (r < 96) wr(16'h0100, d);
            else idle(1);
        end
        idle(2);

        // Reset between a read request and its response
        wr(dataAddr(1), 64'h77);
        rd(statAddr(1));
        #2 rst = 1'b1;
        rx = '0;
        expQ.delete();
        resetModel();
        @(negedge clk);
        checkOutput("midop_reset_tx_zero", 64'(tx == '0), 64'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midop_reset_no_valid", 64'(tx.c2.mmioRdValid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) rd(statAddr(c));
        idle(3);

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/afu_mmio_fifo_bank.md
# afu_mmio_fifo_bank

Parametrised CCI-P MMIO AFU that exposes `NUM_CH` independent FIFOs to the host. Each FIFO is `DEPTH` entries of `WIDTH` bits, with a data register per channel and a status/control register per channel. An MMIO write to a data register pushes; an MMIO read pops. This block replaces the single-register, always-shifting MMIO FIFO AFU. It sits directly under the platform shim on the registered `rx`/`tx` CCI-P ports and serves the mandatory DFH/AFU_ID registers itself.

## Interface
- `NUM_CH`, default 4: number of FIFO channels, 1..8.
- `DEPTH`, default 8: entries per channel; power of two, ≥2.
- `WIDTH`, default 64: data bits per entry, 1..64.
- `AFU_ID`, default `` `AFU_ACCEL_UUID ``: 128-bit AFU ID returned in the DFH block.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `rx`  in  `t_if_ccip_Rx`  CCI-P receive; only `c0.mmioWrValid`, `c0.mmioRdValid`, `c0.hdr` (cast to `t_ccip_c0_ReqMmioHdr`) and `c0.data[63:0]` are used.
- `tx`  out  `t_if_ccip_Tx`  CCI-P transmit; only `c2` is driven. `c0`/`c1` are held at 0.

## Operation
- Addresses are 32-bit-word MMIO addresses; all registers are 64-bit at even addresses.
- DFH block:
  - 0x0000: DFH (type AFU=4'b0001, EOL=1, all else 0).
  - 0x0002: `AFU_ID[63:0]`.
  - 0x0004: `AFU_ID[127:64]`.
  - 0x0006, 0x0008: 0.
- Channel c, 0 ≤ c < `NUM_CH`:
  - DATA at 0x0020+4c.
  - STAT at 0x0022+4c.
- DATA write: push `data[WIDTH-1:0]`.
  - If full: data is dropped, the `ovf` sticky bit is set, and contents are unchanged.
- DATA read: respond with the head entry, zero-extended to 64 bits, and pop.
  - If empty: respond 0, set the `udf` sticky bit, and leave pointers unchanged.
- STAT read layout: {48'b0, count[7:0] at [15:8], 4'b0, udf[3], ovf[2], full[1], empty[0]}.
  - count is 0..`DEPTH`, zero-extended.
  - STAT reads have no side effects.
- STAT write:
  - bit0=1 flushes the channel (count←0, pointers←0; storage content is don't-care).
  - bit1=1 clears `ovf` and `udf`.
  - Both bits may be set together.
  - A write with neither bit set is a no-op.
- Writes to any other address are ignored. Reads of any other address return 0 with a normal response.
- Only one MMIO request is presented per cycle (shared c0 header). If both valids are asserted, the read is serviced and the write is ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. count is `$clog2(DEPTH)+1` bits, so full is `count==DEPTH`.
- Reset clears every channel to count 0 with `ovf`/`udf` = 0, and drives `tx` to all zeros.

## Timing
- Read response:
  - `tx.c2.mmioRdValid` pulses for exactly 1 cycle, on the cycle after `rx.c0.mmioRdValid`.
  - `tx.c2.hdr.tid` is copied from the request; `tx.c2.data` is registered in the same cycle.
  - Back-to-back reads produce back-to-back responses, with no bubble.
- Pop read: the response carries the pre-pop head. Count decrements in the same edge as the response register loads.
  - A following read in the next cycle sees the new head.
- Push: the entry is visible to a DATA read issued in the next cycle (write at cycle N, read request at N+1, response at N+2).
- A STAT read in the cycle after a push/pop/flush reflects the updated state.
- Reset mid-operation: any pending response is dropped (`mmioRdValid`=0) and all FIFOs empty immediately.

## Structure
- `afu_mmio_fifo_pkg` contains:
  - `DFH_ADDR`, `AFU_ID_L_ADDR`, `AFU_ID_H_ADDR`, `CH_BASE_ADDR`=16'h0020, `CH_STRIDE`=4.
  - STAT bit positions and control bit positions (`CTL_FLUSH`=0, `CTL_CLR`=1).
  - The `t_stat` packed struct.
- Sub-module `mmio_fifo_chan`, instantiated `NUM_CH` times via generate:
  - Ports: clk, rst, push, pop, flush, clr, din, dout (combinational head), count, full, empty, ovf, udf.
- The top level contains:
  - Address decode to a one-hot channel select with a data/stat flag.
  - The response mux.
  - The registered `tx.c2` logic.

## Test plan
- Reset, then read 0x0000, 0x0002, 0x0004 → DFH = 64'h1000_0100_0000_0000 and the AFU_ID halves, each response one cycle after its request with matching tid.
- Ch0:
  - Write 0x0020 with 0x11, 0x22, 0x33 → STAT(0x0022) = count 3, empty 0.
  - Then three reads of 0x0020 → responses 0x11, 0x22, 0x33.
  - Then STAT → empty=1.
- Ch1, DEPTH=8:
  - Write 9 values 1..9 → STAT full=1, ovf=1, count=8.
  - Reads return 1..8.
  - A 9th read returns 0 and sets udf.
  - Write STAT=2 → ovf=udf=0.
- Ch2: push 5 values, pop 3, push 6 (wrap) → pops return values 4..5 then the 6 new ones in order; count tracks exactly.
- Channel isolation and flush:
  - Push 0xAA to ch0 and 0xBB to ch3.
  - Write ch0 STAT=1 → ch0 empty; ch3 still reads 0xBB.
  - Unmapped address 0x0100 reads 0, and a write to it changes nothing.
- Assert rst between a read request and its response → no `mmioRdValid` pulse, `tx`=0, all STAT empty after reset release.
